cog_segment_accumulator: RTL and testbench

Consumes the per-figure pixel stream produced by the CoG receiver FSM and reduces each figure segment into its centre-of-gravity moments. It sits directly downstream of the receiver. For every figure segment on a line it accumulates the intensity sum, the first moment (Σ I·x) and the length. It then queues the record into a small output FIFO for the CoG divider stage. The upstream stage has no backpressure, so records that cannot be queued are dropped and flagged.

---
 rtl/cog_pkg.sv | 17 +
 rtl/cog_segment_accumulator_if.sv | 16 +
 rtl/cog_seg_fifo.sv | 38 +++
 rtl/cog_segment_accumulator.sv | 162 ++++++++++++++++
 tb/tb_cog_segment_accumulator.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cog_pkg.sv
// Shared types for the CoG segment accumulator: record layout, FSM states, widths.
package cog_pkg;
  localparam int PIX_W = 8;
  localparam int X_W   = 11;
  localparam int SUM_W = PIX_W + X_W;
  localparam int MOM_W = PIX_W + 2 * X_W;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [MOM_W-1:0] moment;
    logic [X_W-1:0]   len;
    logic [X_W-1:0]   start;
    logic [X_W-1:0]   line;
  } seg_record_t;

  typedef enum logic [1:0] {IDLE, WAIT_FIG, ACCUM} state_t;
endpackage

// File: rtl/cog_segment_accumulator_if.sv
// Segment record output bus towards the CoG divider (valid/ready, show-ahead).
interface cog_segment_accumulator_if;
  import cog_pkg::*;
  logic [SUM_W-1:0] o_seg_sum;
  logic [MOM_W-1:0] o_seg_moment;
  logic [X_W-1:0]   o_seg_len;
  logic [X_W-1:0]   o_seg_start;
  logic [X_W-1:0]   o_seg_line;
  logic             o_seg_valid;
  logic             i_seg_ready;

  modport master (output o_seg_sum, o_seg_moment, o_seg_len, o_seg_start, o_seg_line,
                  o_seg_valid, input i_seg_ready);
  modport slave  (input o_seg_sum, o_seg_moment, o_seg_len, o_seg_start, o_seg_line,
                  o_seg_valid, output i_seg_ready);
endinterface

// File: rtl/cog_seg_fifo.sv
// Show-ahead synchronous FIFO of segment records; caller never pushes when full without a pop.
module cog_seg_fifo
  import cog_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  seg_record_t wdata,
  input  logic        pop,
  output seg_record_t rdata,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  seg_record_t   mem [DEPTH];
  logic [AW:0]   wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/cog_segment_accumulator.sv
// Reduces each figure segment of a line to {sum, moment, len, start, line} and queues it.
module cog_segment_accumulator
  import cog_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int WIDTH      = 1280,
  parameter int HEIGHT     = 1024,
  parameter int MIN_LEN    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_aresetn,
  input  logic [DATA_WIDTH-1:0] i_data_image,
  input  logic                  i_data_valid,
  input  logic [X_W-1:0]        i_start_point,
  input  logic                  i_start_of_fig,
  input  logic                  i_end_of_fig,
  input  logic                  i_end_of_line,
  input  logic                  i_end_of_frame,
  input  logic                  i_new_frame,
  cog_segment_accumulator_if.master seg,
  output logic                  o_frame_done,
  output logic                  o_overflow,
  output logic                  o_protocol_err
);
  state_t           state, state_n;
  logic [SUM_W-1:0] sum_q, sum_n;
  logic [MOM_W-1:0] mom_q, mom_n;
  logic [X_W-1:0]   len_q, len_n, start_q, start_n, x_q, x_n, line_q, line_n;
  logic             fin, perr_set, flag_clr, done_n, keep;
  seg_record_t      fin_rec, rec_p1, head;
  logic             vld_p1, full, empty, pop, push_ok;

  function automatic logic [MOM_W-1:0] mul(input logic [DATA_WIDTH-1:0] p,
                                           input logic [X_W-1:0] x);
    logic [SUM_W-1:0] prod;
    prod = SUM_W'(p) * SUM_W'(x);
    return MOM_W'(prod);
  endfunction

  function automatic logic [X_W-1:0] sat_line(input logic [X_W-1:0] l);
    return (l >= X_W'(HEIGHT - 1)) ? l : l + 1'b1;
  endfunction

  function automatic logic [X_W-1:0] sat_len(input logic [X_W-1:0] l);
    return (l >= X_W'(WIDTH)) ? l : l + 1'b1;
  endfunction

  always_comb begin
    state_n  = state;
    sum_n    = sum_q;
    mom_n    = mom_q;
    len_n    = len_q;
    start_n  = start_q;
    x_n      = x_q;
    line_n   = line_q;
    fin      = 1'b0;
    perr_set = 1'b0;
    flag_clr = 1'b0;
    done_n   = 1'b0;
    if (state == IDLE) begin
      if (i_new_frame) begin
        line_n   = '0;
        flag_clr = 1'b1;
        state_n  = WAIT_FIG;
      end
    end else if (i_new_frame) begin
      line_n  = '0;
      state_n = WAIT_FIG;
    end else begin
      // A new figure start always wins; inside ACCUM it abandons the open segment.
      if (i_start_of_fig && i_data_valid) begin
        perr_set = (state == ACCUM);
        sum_n    = SUM_W'(i_data_image);
        mom_n    = mul(i_data_image, i_start_point);
        len_n    = X_W'(1);
        start_n  = i_start_point;
        x_n      = i_start_point + 1'b1;
        state_n  = ACCUM;
        if (i_end_of_fig) begin
          fin     = 1'b1;
          state_n = WAIT_FIG;
        end
      end else if (state == ACCUM) begin
        if (i_data_valid) begin
          sum_n = sum_q + SUM_W'(i_data_image);
          mom_n = mom_q + mul(i_data_image, x_q);
          len_n = sat_len(len_q);
          x_n   = x_q + 1'b1;
        end
        if (i_end_of_fig) begin
          fin     = 1'b1;
          state_n = WAIT_FIG;
        end
      end else if (i_end_of_fig) begin
        perr_set = 1'b1;
      end
      if (i_end_of_line) line_n = sat_line(line_q);
      if (i_end_of_frame) begin
        if (state_n == ACCUM) perr_set = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
    end
  end

  assign keep    = fin && (len_n >= X_W'(MIN_LEN));
  assign fin_rec = {sum_n, mom_n, len_n, start_n, line_q};

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state          <= IDLE;
      line_q         <= '0;
      vld_p1         <= 1'b0;
      o_frame_done   <= 1'b0;
      o_overflow     <= 1'b0;
      o_protocol_err <= 1'b0;
    end else begin
      state        <= state_n;
      line_q       <= line_n;
      vld_p1       <= keep;
      o_frame_done <= done_n;
      if (flag_clr) begin
        o_overflow     <= 1'b0;
        o_protocol_err <= 1'b0;
      end
      if (perr_set) o_protocol_err <= 1'b1;
      if (vld_p1 && !push_ok) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    sum_q   <= sum_n;
    mom_q   <= mom_n;
    len_q   <= len_n;
    start_q <= start_n;
    x_q     <= x_n;
    if (keep) rec_p1 <= fin_rec;
  end

  // p1 -> FIFO: a same-edge pop frees the slot, so a full FIFO still accepts.
  assign pop     = !empty && seg.i_seg_ready;
  assign push_ok = vld_p1 && (!full || pop);

  cog_seg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_sys_clk),
    .rst_n (i_sys_aresetn),
    .push  (push_ok),
    .wdata (rec_p1),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign seg.o_seg_valid  = !empty;
  assign seg.o_seg_sum    = empty ? '0 : head.sum;
  assign seg.o_seg_moment = empty ? '0 : head.moment;
  assign seg.o_seg_len    = empty ? '0 : head.len;
  assign seg.o_seg_start  = empty ? '0 : head.start;
  assign seg.o_seg_line   = empty ? '0 : head.line;
endmodule

// File: tb/tb_cog_segment_accumulator.sv
// Directed plus randomized bench for cog_segment_accumulator with a queue-based record model.
module tb_cog_segment_accumulator;
  import cog_pkg::*;

  localparam int DEPTH = 8;
  localparam int MINL  = 3;
  localparam int HGT   = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_data_image;
  logic       i_data_valid, i_start_of_fig, i_end_of_fig, i_end_of_line, i_end_of_frame, i_new_frame;
  logic [10:0] i_start_point;
  logic       o_frame_done, o_overflow, o_protocol_err;

  cog_segment_accumulator_if seg();

  cog_segment_accumulator dut (
    .i_sys_clk      (clk),
    .i_sys_aresetn  (rst_n),
    .i_data_image   (i_data_image),
    .i_data_valid   (i_data_valid),
    .i_start_point  (i_start_point),
    .i_start_of_fig (i_start_of_fig),
    .i_end_of_fig   (i_end_of_fig),
    .i_end_of_line  (i_end_of_line),
    .i_end_of_frame (i_end_of_frame),
    .i_new_frame    (i_new_frame),
    .seg            (seg),
    .o_frame_done   (o_frame_done),
    .o_overflow     (o_overflow),
    .o_protocol_err (o_protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     sum;
    longint mom;
    int     len;
    int     start;
    int     line;
  } exp_rec_t;

  exp_rec_t exp_q[$];
  int       px[$];
  int       n_assert = 0;
  int       n_fail   = 0;
  bit       m_active, m_open, m_ovf, m_perr;
  int       m_line;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_data_image   = '0;
    i_data_valid   = 1'b0;
    i_start_point  = '0;
    i_start_of_fig = 1'b0;
    i_end_of_fig   = 1'b0;
    i_end_of_line  = 1'b0;
    i_end_of_frame = 1'b0;
    i_new_frame    = 1'b0;
  endtask

  task automatic new_frame();
    i_new_frame = 1'b1;
    step();
    i_new_frame = 1'b0;
    if (!m_active) begin
      m_ovf  = 1'b0;
      m_perr = 1'b0;
    end
    m_line   = 0;
    m_active = 1'b1;
    m_open   = 1'b0;
  endtask

  task automatic end_frame();
    i_end_of_frame = 1'b1;
    step();
    i_end_of_frame = 1'b0;
    if (m_active && m_open) m_perr = 1'b1;
    check("frame_done_pulse", o_frame_done, 1);
    step();
    check("frame_done_low", o_frame_done, 0);
    m_active = 1'b0;
    m_open   = 1'b0;
  endtask

  // Sends the pixels in px as one figure starting at sx; the model derives the record.
  task automatic send_fig(input int sx, input bit close, input bit eol, input bit eof);
    int     s;
    longint m;
    int     n;
    s = 0;
    m = 0;
    n = px.size();
    for (int i = 0; i < n; i++) begin
      i_data_valid   = 1'b1;
      i_data_image   = 8'(px[i]);
      i_start_of_fig = (i == 0);
      i_start_point  = 11'(sx);
      i_end_of_fig   = close && (i == n - 1);
      i_end_of_line  = eol && (i == n - 1);
      i_end_of_frame = eof && (i == n - 1);
      s += px[i];
      m += longint'(px[i]) * longint'(sx + i);
      step();
    end
    clear_inputs();
    if (m_active) begin
      if (m_open) m_perr = 1'b1;
      m_open = !close;
      if (close && n >= MINL) begin
        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back('{s, m, n, sx, m_line});
      end
      if (eol) m_line = (m_line < HGT - 1) ? m_line + 1 : m_line;
      if (eof) begin
        if (!close) m_perr = 1'b1;
        m_active = 1'b0;
        m_open   = 1'b0;
        check("eof_frame_done", o_frame_done, 1);
      end
    end
  endtask

  task automatic drain(input string tag);
    int       budget;
    exp_rec_t e;
    budget = 4 * exp_q.size() + 10;
    step();
    step();
    seg.i_seg_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (seg.o_seg_valid) begin
        e = exp_q.pop_front();
        check({tag, "_sum"},   seg.o_seg_sum,    e.sum);
        check({tag, "_mom"},   seg.o_seg_moment, e.mom);
        check({tag, "_len"},   seg.o_seg_len,    e.len);
        check({tag, "_start"}, seg.o_seg_start,  e.start);
        check({tag, "_line"},  seg.o_seg_line,   e.line);
      end
      step();
      budget--;
    end
    seg.i_seg_ready = 1'b0;
    check({tag, "_records_left"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_empty_after"}, seg.o_seg_valid, 0);
  endtask

  initial begin
    int len, sx;
    bit eol;
    clear_inputs();
    seg.i_seg_ready = 1'b0;
    m_active = 0; m_open = 0; m_ovf = 0; m_perr = 0; m_line = 0;
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_valid", seg.o_seg_valid, 0);
    check("rst_sum", seg.o_seg_sum, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_perr", o_protocol_err, 0);
    check("rst_done", o_frame_done, 0);
    rst_n = 1'b1;
    step();

    // Figures before any new_frame are ignored.
    px = '{5, 6, 7, 8};
    send_fig(50, 1, 0, 0);
    step(); step();
    check("idle_ignored", seg.o_seg_valid, 0);

    new_frame();
    px = '{10, 20, 30};
    send_fig(100, 1, 0, 0);
    check("lat_valid_1cyc", seg.o_seg_valid, 0);
    step();
    check("lat_valid_2cyc", seg.o_seg_valid, 1);
    check("t1_sum", seg.o_seg_sum, 60);
    check("t1_mom", seg.o_seg_moment, 6080);
    check("t1_start", seg.o_seg_start, 100);
    drain("t1");

    px = '{1, 2};
    send_fig(200, 1, 0, 0);
    step(); step();
    check("short_valid", seg.o_seg_valid, 0);
    check("short_ovf", o_overflow, 0);
    check("short_perr", o_protocol_err, 0);

    for (int k = 0; k < 9; k++) begin
      px = '{k + 1, 2, 3};
      send_fig(10 * k + 5, 1, 0, 0);
      step();
    end
    step(); step();
    check("full_ovf", o_overflow, m_ovf);
    check("full_ovf_set", o_overflow, 1);
    drain("fifo9");

    end_frame();
    new_frame();
    check("ovf_cleared", o_overflow, 0);
    repeat (5) begin
      i_end_of_line = 1'b1;
      step();
      i_end_of_line = 1'b0;
      m_line++;
    end
    px = '{9, 9, 9};
    send_fig(300, 1, 1, 0);
    px = '{4, 4, 4, 4};
    send_fig(310, 1, 0, 0);
    drain("line");

    px = '{1, 1, 1, 1};
    send_fig(10, 0, 0, 0);
    px = '{3, 3, 3};
    send_fig(40, 1, 0, 0);
    check("restart_perr", o_protocol_err, 1);
    drain("restart");
    end_frame();

    new_frame();
    check("perr_cleared", o_protocol_err, 0);
    i_end_of_fig = 1'b1;
    step();
    i_end_of_fig = 1'b0;
    m_perr = 1'b1;
    check("eof_in_wait_perr", o_protocol_err, 1);
    px = '{2, 4, 6};
    send_fig(500, 1, 0, 1);
    drain("eof_fig");
    check("idle_perr_kept", o_protocol_err, m_perr);

    new_frame();
    px = '{7, 7, 7};
    send_fig(600, 1, 0, 0);
    send_fig(650, 1, 0, 0);
    step(); step();
    check("pre_rst_valid", seg.o_seg_valid, 1);
    px = '{8, 8};
    send_fig(700, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", seg.o_seg_valid, 0);
    check("async_rst_sum", seg.o_seg_sum, 0);
    exp_q.delete();
    m_active = 0; m_open = 0; m_ovf = 0; m_perr = 0; m_line = 0;
    step();
    rst_n = 1'b1;
    step();
    new_frame();
    px = '{11, 12, 13, 14};
    send_fig(800, 1, 0, 0);
    drain("post_rst");

    for (int k = 0; k < 24; k++) begin
      len = int'($urandom_range(1, 6));
      sx  = int'($urandom_range(0, 1280 - len));
      eol = ($urandom_range(0, 3) == 0);
      px.delete();
      for (int i = 0; i < len; i++) px.push_back(int'($urandom_range(0, 255)));
      send_fig(sx, 1, eol, 0);
      repeat ($urandom_range(0, 2)) step();
      if ((k % 5) == 4) drain("rand");
    end
    drain("rand_tail");

    px.delete();
    for (int i = 0; i < 1280; i++) px.push_back(255);
    send_fig(0, 1, 0, 0);
    drain("max_line");
    end_frame();
    check("final_ovf", o_overflow, m_ovf);
    check("final_perr", o_protocol_err, m_perr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
